// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage that sits in front of a combinational,
// word-addressed instruction memory.
//
// The block owns the PC and presents it as the byte address. The word returned
// for that address is captured in the same cycle into a 2-entry FIFO of
// {pc, instr, fault}. The FIFO head is offered to the decoder.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   imem_addr      byte address to instruction memory (the PC register)
//   imem_data      instruction word returned combinationally for imem_addr
//   redirect_valid branch/jump taken this cycle; flushes the buffer
//   redirect_pc    branch/jump target; bits [1:0] are ignored
//   out_valid      head entry valid
//   out_ready      decoder accepts head entry
//   out_instr      head instruction word (0 when empty)
//   out_pc         head PC (0 when empty)
//   out_pc4        out_pc + 4, modulo 2^32
//   out_fault      head fetched from word index >= IMEM_WORDS
//
// Handshake: the head entry transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid depends only on registered state. Once
// out_valid is asserted it stays asserted until the transfer or a
// redirect/reset flush. out_ready is ignored while out_valid is 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic        out_fault
);

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  logic [31:0] pc;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;

  logic [31:0] pc_mem    [2];
  logic [31:0] instr_mem [2];
  logic        fault_mem [2];

  logic push;
  logic pop;
  logic fetch_fault;

  // A push depends only on count, not on out_ready. When the buffer is full,
  // the fetch stalls for that cycle even if the head is popped. This keeps the
  // decoder's ready signal out of the PC/memory-address path.
  assign push        = !redirect_valid && (count != 2'd2);
  assign pop         = out_valid && out_ready;
  assign fetch_fault = (pc[31:2] >= IMEM_LIMIT);

  assign imem_addr = pc;

  // Control state: PC, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (redirect_valid) begin
      // A pop in this cycle is still accepted by the decoder. The flush then
      // discards whatever remains in the buffer.
      pc     <= redirect_pc & 32'hFFFF_FFFC;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data storage needs no reset. Occupancy qualifies every read. A write
  // during a reset cycle lands in a slot that the cleared pointers treat as
  // empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= imem_data;
      fault_mem[wr_ptr] <= fetch_fault;
    end
  end

  // Head outputs come only from storage, so there is no combinational path
  // from imem_data to the decoder.
  always_comb begin
    out_valid = (count != 2'd0);
    out_instr = 32'd0;
    out_pc    = 32'd0;
    out_fault = 1'b0;
    if (out_valid) begin
      out_instr = instr_mem[rd_ptr];
      out_pc    = pc_mem[rd_ptr];
      out_fault = fault_mem[rd_ptr];
    end
  end

  assign out_pc4 = out_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. The bench provides a memory model that returns
// 0x1000_0000 + word index for every address. A queue-based reference model
// follows the fetch and flush rules.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_WORDS = 32;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        out_fault;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .out_fault      (out_fault)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign imem_data = mem_word(imem_addr);

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] m_pc;

  // Apply one clock edge of the fetch rules to the queue model.
  task automatic model_step();
    int     n;
    entry_t e;
    n = exp_q.size();
    if (rst) begin
      m_pc = RESET_PC;
      exp_q.delete();
    end else if (redirect_valid) begin
      exp_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (n > 0 && out_ready) e = exp_q.pop_front();
      if (n < 2) begin
        e.pc    = m_pc;
        e.instr = mem_word(m_pc);
        e.fault = ((m_pc >> 2) >= IMEM_WORDS);
        exp_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reset, then let two fetches fill the buffer with pc 0 and 4 (pc = 8).
  task automatic fill_two();
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", out_valid); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, RESET_PC); end
    checks++; if (out_pc !== 32'd0 || out_instr !== 32'd0 || out_fault !== 1'b0) begin
      errors++; $display("FAIL reset_empty_outs got pc %h instr %h fault %h exp 0 0 0", out_pc, out_instr, out_fault);
    end
    checks++; if (out_pc4 !== 32'd4) begin errors++; $display("FAIL reset_pc4 got %h exp 4", out_pc4); end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %h exp 1", i, out_valid); end
      checks++; if (out_pc !== 32'(4 * i) || out_instr !== 32'h1000_0000 + 32'(i)) begin
        errors++; $display("FAIL stream_head[%0d] got %h/%h exp %h/%h", i, out_pc, out_instr, 4 * i, 32'h1000_0000 + 32'(i));
      end
      checks++; if (out_pc4 !== 32'(4 * i + 4) || imem_addr !== 32'(4 * i + 4)) begin
        errors++; $display("FAIL stream_pc4_addr[%0d] got %h/%h exp %h", i, out_pc4, imem_addr, 4 * i + 4);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL bp_addr got %h exp 8", imem_addr); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0) begin errors++; $display("FAIL bp_head got %h/%h exp 1/0", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'h1000_0000 + 32'(i)) begin
        errors++; $display("FAIL bp_drain[%0d] got %h/%h/%h exp 1/%h/%h", i, out_valid, out_pc, out_instr, 4 * i, 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_redirect();
    fill_two();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_flush got %h/%h exp 0/40", out_valid, imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h1000_0010) begin
      errors++; $display("FAIL redir_first got %h/%h/%h exp 1/40/10000010", out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc !== 32'h44 || out_instr !== 32'h1000_0011) begin errors++; $display("FAIL redir_second got %h/%h exp 44/10000011", out_pc, out_instr); end
  endtask

  task automatic test_redirect_pop();
    fill_two();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0010;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h10) begin errors++; $display("FAIL redir_pop_flush got %h/%h exp 0/10", out_valid, imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin errors++; $display("FAIL redir_pop_next got %h/%h exp 1/10", out_valid, out_pc); end
  endtask

  task automatic test_fault_boundary();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_007C;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (out_pc !== 32'h7C || out_fault !== 1'b0) begin errors++; $display("FAIL fault_last_in got %h/%h exp 7c/0", out_pc, out_fault); end
    tick();
    checks++; if (out_pc !== 32'h80 || out_fault !== 1'b1 || out_instr !== 32'h1000_0020) begin
      errors++; $display("FAIL fault_first_out got %h/%h/%h exp 80/1/10000020", out_pc, out_fault, out_instr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 0", imem_addr); end
    checks++; if (out_pc !== 32'hFFFF_FFFC || out_pc4 !== 32'h0 || out_fault !== 1'b1) begin
      errors++; $display("FAIL wrap_head got %h/%h/%h exp fffffffc/0/1", out_pc, out_pc4, out_fault);
    end
  endtask

  task automatic test_reset_mid();
    fill_two();
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    checks++; if (out_valid !== 1'b0 || imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_mid got %h/%h exp 0/%h", out_valid, imem_addr, RESET_PC); end
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin errors++; $display("FAIL reset_mid_next got %h/%h exp 1/%h", out_valid, out_pc, RESET_PC); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_first got %h exp 0", out_valid); end
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h200) begin errors++; $display("FAIL b2b_second got %h/%h exp 0/200", out_valid, imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin errors++; $display("FAIL b2b_result got %h/%h exp 1/200", out_valid, out_pc); end
  endtask

  task automatic test_random();
    entry_t head;
    logic   exp_valid;
    for (int c = 0; c < 600; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40 * 4 + 3));
      out_ready      = ($urandom_range(0, 3) != 0);
      tick();
      exp_valid = (exp_q.size() != 0);
      head = exp_valid ? exp_q[0] : '0;
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", c, imem_addr, m_pc); end
      checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %h exp %h", c, out_valid, exp_valid); end
      checks++; if (out_pc !== head.pc || out_instr !== head.instr || out_fault !== head.fault) begin
        errors++; $display("FAIL rnd_head[%0d] got %h/%h/%h exp %h/%h/%h", c, out_pc, out_instr, out_fault, head.pc, head.instr, head.fault);
      end
      checks++; if (out_pc4 !== head.pc + 32'd4) begin errors++; $display("FAIL rnd_pc4[%0d] got %h exp %h", c, out_pc4, head.pc + 32'd4); end
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b0;
    m_pc = RESET_PC;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_fault_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
